// File: rtl/rsc2_frame_ctrl_pkg.sv
// rsc2 frame controller shared types and frame-length tables.
// Tables are stored as {N, N-1} pairs built at elaboration time.
package rsc2_frame_ctrl_pkg;

    localparam int NW       = 13;
    localparam int DVB_SIZE = 34;
    localparam int WMX_SIZE = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [NW-1:0] n;
        logic [NW-1:0] nm1;
    } nent_t;

    function automatic nent_t mk_ent(input int n);
        nent_t e;
        e.n   = NW'(n);
        e.nm1 = NW'(n - 1);
        return e;
    endfunction

    localparam nent_t DVB_TAB [DVB_SIZE] = '{
        mk_ent(48),  mk_ent(64),  mk_ent(212), mk_ent(220),
        mk_ent(228), mk_ent(424), mk_ent(432), mk_ent(440),
        mk_ent(752), mk_ent(848), mk_ent(856), mk_ent(864),
        mk_ent(56),  mk_ent(88),  mk_ent(96),  mk_ent(112),
        mk_ent(120), mk_ent(128), mk_ent(152), mk_ent(168),
        mk_ent(176), mk_ent(184), mk_ent(200), mk_ent(232),
        mk_ent(256), mk_ent(304), mk_ent(352), mk_ent(400),
        mk_ent(480), mk_ent(512), mk_ent(600), mk_ent(704),
        mk_ent(1024), mk_ent(2396)
    };

    localparam nent_t WMX_TAB [WMX_SIZE] = '{
        mk_ent(24),  mk_ent(36),  mk_ent(48),  mk_ent(72),
        mk_ent(96),  mk_ent(108), mk_ent(120), mk_ent(144),
        mk_ent(180), mk_ent(192), mk_ent(216), mk_ent(240),
        mk_ent(480), mk_ent(960), mk_ent(1440), mk_ent(1920),
        mk_ent(2400), mk_ent(30), mk_ent(42),  mk_ent(54),
        mk_ent(60),  mk_ent(66),  mk_ent(78),  mk_ent(84),
        mk_ent(90),  mk_ent(102), mk_ent(114), mk_ent(126),
        mk_ent(132), mk_ent(138), mk_ent(150), mk_ent(4800)
    };

endpackage

// File: rtl/rsc2_frame_ctrl_if.sv
// rsc2 frame controller handshake bundle.
// master: start/advance side; slave: the controller itself.
interface rsc2_frame_ctrl_if #(
    parameter int pW = 13
);
    logic          iclkena;
    logic          istart;
    logic [5:0]    iptype;
    logic          imode;
    logic          ival;
    logic          obusy;
    logic [pW-1:0] oN;
    logic [pW-1:0] oNm1;
    logic [pW-1:0] oaddr;
    logic          oval;
    logic          osop;
    logic          oeop;
    logic          odone;
    logic          oerr;

    modport master (
        output iclkena, istart, iptype, imode, ival,
        input  obusy, oN, oNm1, oaddr,
        input  oval, osop, oeop, odone, oerr
    );

    modport slave (
        input  iclkena, istart, iptype, imode, ival,
        output obusy, oN, oNm1, oaddr,
        output oval, osop, oeop, odone, oerr
    );
endinterface

// File: rtl/rsc2_ntable_rom.sv
// Registered, mode-muxed frame-length table read with range check.
// Ports: i_en/i_idx/i_mode in; o_n/o_nm1/o_err valid one cycle later.
// RSC2_FRAME_CTRL_WIMAX_EN compiles in the WiMAX table and i_mode.
module rsc2_ntable_rom
    import rsc2_frame_ctrl_pkg::*;
#(
    parameter int pW        = 13,
    parameter int pDVB_SIZE = 34,
    parameter int pWMX_SIZE = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clkena,
    input  logic          i_en,
    input  logic [5:0]    i_idx,
    input  logic          i_mode,
    output logic [pW-1:0] o_n,
    output logic [pW-1:0] o_nm1,
    output logic          o_err
);
    // Never index past the physical table, whatever the size parameter.
    localparam int DVB_LIM = (pDVB_SIZE < DVB_SIZE) ? pDVB_SIZE : DVB_SIZE;

    nent_t w_ent;
    logic  w_err;

`ifdef RSC2_FRAME_CTRL_WIMAX_EN
    localparam int WMX_LIM = (pWMX_SIZE < WMX_SIZE) ? pWMX_SIZE : WMX_SIZE;

    always_comb begin
        w_ent = '0;
        w_err = 1'b0;
        if (i_mode) begin
            w_err = int'(i_idx) >= WMX_LIM;
            if (!w_err) w_ent = WMX_TAB[i_idx[4:0]];
        end else begin
            w_err = int'(i_idx) >= DVB_LIM;
            if (!w_err) w_ent = DVB_TAB[i_idx];
        end
    end
`else
    localparam int unused_wmx = pWMX_SIZE;
    logic w_unused_mode;
    assign w_unused_mode = i_mode;

    always_comb begin
        w_ent = '0;
        w_err = int'(i_idx) >= DVB_LIM;
        if (!w_err) w_ent = DVB_TAB[i_idx];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_n   <= '0;
            o_nm1 <= '0;
            o_err <= 1'b0;
        end else if (i_clkena && i_en) begin
            o_n   <= pW'(w_ent.n);
            o_nm1 <= pW'(w_ent.nm1);
            o_err <= w_err;
        end
    end
endmodule

// File: rtl/rsc2_frame_ctrl.sv
// rsc2 per-frame length controller: table lookup, duobit counter, framing.
// Ports: iclk, ireset_n (async, active low), bus (slave modport).
// RSC2_FRAME_CTRL_WIMAX_EN enables the WiMAX table and imode.
module rsc2_frame_ctrl
    import rsc2_frame_ctrl_pkg::*;
#(
    parameter int pW        = 13,
    parameter int pDVB_SIZE = 34,
    parameter int pWMX_SIZE = 32
) (
    input  logic          iclk,
    input  logic          ireset_n,
    rsc2_frame_ctrl_if.slave bus
);
    state_t        r_state;
    state_t        w_nxt;
    logic          w_acc;
    logic          w_beat;
    logic [pW-1:0] w_rn;
    logic [pW-1:0] w_rnm1;
    logic          w_rerr;

    logic [pW-1:0] r_n;
    logic [pW-1:0] r_nm1;
    logic [pW-1:0] r_cnt;
    logic [pW-1:0] r_addr;
    logic          r_busy;
    logic          r_val;
    logic          r_sop;
    logic          r_eop;
    logic          r_done;
    logic          r_err;

    // The table read itself samples iptype/imode on the accepted start.
    rsc2_ntable_rom #(
        .pW        (pW),
        .pDVB_SIZE (pDVB_SIZE),
        .pWMX_SIZE (pWMX_SIZE)
    ) u_rom (
        .i_clk    (iclk),
        .i_rst_n  (ireset_n),
        .i_clkena (bus.iclkena),
        .i_en     (w_acc),
        .i_idx    (bus.iptype),
        .i_mode   (bus.imode),
        .o_n      (w_rn),
        .o_nm1    (w_rnm1),
        .o_err    (w_rerr)
    );

    assign w_acc  = (r_state == S_IDLE) && bus.istart;
    // r_eop blocks a further beat while the eop beat is on the outputs.
    assign w_beat = (r_state == S_RUN) && bus.ival && !r_eop;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n)        r_state <= S_IDLE;
        else if (bus.iclkena) r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.istart) w_nxt = S_LOOKUP;
            S_LOOKUP: w_nxt = w_rerr ? S_IDLE : S_RUN;
            S_RUN:    if (r_eop) w_nxt = S_DONE;
            S_DONE:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_n    <= '0;
            r_nm1  <= '0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_busy <= 1'b0;
            r_val  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (bus.iclkena) begin
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (w_nxt == S_DONE);
            r_val  <= w_beat;
            r_sop  <= w_beat && (r_cnt == '0);
            r_eop  <= w_beat && (r_cnt == r_nm1);
            if (w_acc) r_err <= 1'b0;
            if (r_state == S_LOOKUP) begin
                r_n   <= w_rn;
                r_nm1 <= w_rnm1;
                r_err <= w_rerr;
                r_cnt <= '0;
            end
            if (w_beat) begin
                r_addr <= r_cnt;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.obusy = r_busy;
    assign bus.oN    = r_n;
    assign bus.oNm1  = r_nm1;
    assign bus.oaddr = r_addr;
    assign bus.oval  = r_val;
    assign bus.osop  = r_sop;
    assign bus.oeop  = r_eop;
    assign bus.odone = r_done;
    assign bus.oerr  = r_err;
endmodule

// File: tb/tb_rsc2_frame_ctrl.sv
// Directed bench for rsc2_frame_ctrl.
// Table entries used: DVB 0 (N=48), 2 (N=212), 31 (704), 33 (2396); WiMAX 31 (4800).
module tb_rsc2_frame_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rsc2_frame_ctrl_if #(.pW(13)) bus ();

    rsc2_frame_ctrl #(
        .pW        (13),
        .pDVB_SIZE (34),
        .pWMX_SIZE (32)
    ) dut (
        .iclk     (clk),
        .ireset_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`define CHK(tag, obs, exp) \
    begin \
        n_tests++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [5:0] pt, input logic md);
        bus.istart = 1'b1;
        bus.iptype = pt;
        bus.imode  = md;
        tick();
        bus.istart = 1'b0;
    endtask

    // Runs a frame from RUN; counts beats, checks index order and framing.
    task automatic frame(input int budget, input bit rnd, input int inj,
                         input int n_exp, output int beats,
                         output int bad, output bit got_done);
        int  exp_a;
        bit  e;
        exp_a    = 0;
        beats    = 0;
        bad      = 0;
        got_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            bus.ival    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.iclkena = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.istart  = (c == inj);
            bus.iptype  = 6'd2;
            e = bus.iclkena;
            tick();
            if (e && bus.oval) begin
                if (bus.oaddr !== 13'(exp_a)) bad++;
                if (bus.osop !== (exp_a == 0)) bad++;
                if (bus.oeop !== (exp_a == n_exp - 1)) bad++;
                beats++;
                exp_a++;
            end
            if (e && bus.odone) begin
                got_done = 1'b1;
                break;
            end
        end
        bus.istart  = 1'b0;
        bus.iclkena = 1'b1;
        bus.ival    = 1'b0;
    endtask

    int beats;
    int bad;
    bit got_done;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.iclkena = 1'b1;
        bus.istart  = 1'b0;
        bus.iptype  = '0;
        bus.imode   = 1'b0;
        bus.ival    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        `CHK("rst obusy", bus.obusy, 1'b0)
        `CHK("rst oval", bus.oval, 1'b0)
        `CHK("rst odone", bus.odone, 1'b0)
        `CHK("rst oerr", bus.oerr, 1'b0)
        `CHK("rst oN", bus.oN, 13'd0)
        `CHK("rst oaddr", bus.oaddr, 13'd0)

        // Reset in the middle of a 48-duobit frame.
        start(6'd0, 1'b0);
        bus.ival = 1'b1;
        for (int k = 0; k < 21; k++) tick();
        `CHK("mid oaddr", bus.oaddr, 13'd19)
        `CHK("mid oval", bus.oval, 1'b1)
        rst_n = 1'b0;
        #1;
        `CHK("arst obusy", bus.obusy, 1'b0)
        `CHK("arst oval", bus.oval, 1'b0)
        `CHK("arst oaddr", bus.oaddr, 13'd0)
        `CHK("arst oN", bus.oN, 13'd0)
        `CHK("arst oNm1", bus.oNm1, 13'd0)
        tick();
        `CHK("arst odone", bus.odone, 1'b0)
        `CHK("arst oeop", bus.oeop, 1'b0)
        bus.ival = 1'b0;
        rst_n    = 1'b1;
        tick();
        start(6'd0, 1'b0);
        tick();
        frame(200, 1'b0, -1, 48, beats, bad, got_done);
        `CHK("restart beats", beats, 48)
        `CHK("restart bad", bad, 0)
        `CHK("restart done", got_done, 1'b1)
        tick();

        // Gapless 48-duobit frame with exact timing.
        start(6'd0, 1'b0);
        `CHK("gl busy", bus.obusy, 1'b1)
        tick();
        `CHK("gl oN", bus.oN, 13'd48)
        `CHK("gl oNm1", bus.oNm1, 13'd47)
        bus.ival = 1'b1;
        bad = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            if (!(bus.oval === 1'b1 && bus.oaddr === 13'(k) &&
                  bus.osop === (k == 0) && bus.oeop === (k == 47) &&
                  bus.odone === 1'b0))
                bad++;
        end
        `CHK("gl beats", bad, 0)
        tick();
        `CHK("gl odone", bus.odone, 1'b1)
        `CHK("gl no extra", bus.oval, 1'b0)
        `CHK("gl busy50", bus.obusy, 1'b1)
        tick();
        `CHK("gl odone off", bus.odone, 1'b0)
        `CHK("gl busy51", bus.obusy, 1'b0)
        bus.ival = 1'b0;

        // 212-duobit frame with ival gaps and clock-enable toggling.
        start(6'd2, 1'b0);
        tick();
        `CHK("gap oN", bus.oN, 13'd212)
        frame(3000, 1'b1, -1, 212, beats, bad, got_done);
        `CHK("gap beats", beats, 212)
        `CHK("gap order", bad, 0)
        `CHK("gap done", got_done, 1'b1)
        tick();
        `CHK("gap idle", bus.obusy, 1'b0)

        // Out-of-range DVB index.
        start(6'd40, 1'b0);
        `CHK("err busy", bus.obusy, 1'b1)
        tick();
        `CHK("err oerr", bus.oerr, 1'b1)
        `CHK("err oN", bus.oN, 13'd0)
        `CHK("err oNm1", bus.oNm1, 13'd0)
        `CHK("err idle", bus.obusy, 1'b0)
        `CHK("err oval", bus.oval, 1'b0)
        `CHK("err odone", bus.odone, 1'b0)
        start(6'd34, 1'b0);
        tick();
        `CHK("err34 oerr", bus.oerr, 1'b1)
        start(6'd33, 1'b0);
        `CHK("err clear", bus.oerr, 1'b0)
        tick();
        `CHK("e33 oN", bus.oN, 13'd2396)
        `CHK("e33 oerr", bus.oerr, 1'b0)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // istart during RUN must be ignored.
        start(6'd0, 1'b0);
        tick();
        frame(200, 1'b0, 10, 48, beats, bad, got_done);
        `CHK("ign beats", beats, 48)
        `CHK("ign order", bad, 0)
        `CHK("ign oN", bus.oN, 13'd48)
        tick();
        `CHK("ign idle", bus.obusy, 1'b0)

        // imode=1, iptype=31.
        start(6'd31, 1'b1);
        tick();
`ifdef RSC2_FRAME_CTRL_WIMAX_EN
        `CHK("mode oN", bus.oN, 13'd4800)
        `CHK("mode oNm1", bus.oNm1, 13'd4799)
`else
        `CHK("mode oN", bus.oN, 13'd704)
        `CHK("mode oNm1", bus.oNm1, 13'd703)
`endif
        `CHK("mode oerr", bus.oerr, 1'b0)
        rst_n = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rsc2_frame_ctrl.md
# rsc2_frame_ctrl

Per-frame length controller for the rsc2 codec: on a start strobe it captures the permutation type, performs a registered lookup of the frame length N (in duobits) and N-1 from a mode-selectable table, and then drives a duobit address counter with sop/eop/done framing. It replaces purely combinational length decoding at the head of the encoder/decoder datapath. The interleaver address generator and the input/output buffers are slaved to its counter.

## Interface
- pW, 13, width of N, N-1 and the address counter; must hold max table N-1
- pDVB_SIZE, 34, number of DVB table entries (iptype 0..33)
- pWMX_SIZE, 32, number of WiMAX table entries (iptype 0..31)
- iclk  in  1  clock
- ireset_n  in  1  asynchronous reset, active low
- iclkena  in  1  clock enable; all state frozen when low
- istart  in  1  frame start strobe, accepted only when obusy=0
- iptype  in  6  permutation type, sampled with istart
- imode  in  1  table select, sampled with istart: 0 = DVB, 1 = WiMAX
- ival  in  1  consumer advance strobe, one duobit per cycle
- obusy  out  1  frame in progress (LOOKUP, RUN or DONE)
- oN  out  pW  captured frame length in duobits
- oNm1  out  pW  oN - 1
- oaddr  out  pW  current duobit index
- oval  out  1  oaddr valid strobe
- osop  out  1  first duobit of frame (with oval)
- oeop  out  1  last duobit of frame (with oval)
- odone  out  1  one-cycle end-of-frame pulse
- oerr  out  1  sticky: last start had out-of-range iptype; cleared by next accepted istart

## Operation
- FSM states: IDLE, LOOKUP, RUN, DONE. All transitions qualified by iclkena.
- IDLE: obusy=0. istart=1 -> latch iptype/imode, clear oerr, go LOOKUP.
- LOOKUP: one registered table read. Out-of-range index (DVB: iptype >= pDVB_SIZE; WiMAX: iptype >= pWMX_SIZE) -> oerr=1, oN=oNm1=0, go IDLE without asserting odone. Otherwise load oN/oNm1, clear counter, go RUN.
- RUN: ival=1 -> emit oval with oaddr = count, then count+1. osop when count=0. oeop when count=oNm1. After the eop beat, go DONE. ival=0 -> hold, no oval.
- DONE: odone=1 for one cycle, go IDLE. oN/oNm1 stay held until the next lookup.
- istart when obusy=1 is ignored. Nothing is queued and captured parameters are unchanged.
- N=1 entries are not present in any table. The eop check is still required to work for oNm1=0 (osop and oeop in the same beat).
- oNm1 is computed at table-build time in the package, not by an RTL subtractor.

## Timing
- Reset values: state IDLE; obusy, oval, osop, oeop, odone, oerr = 0; oN, oNm1, oaddr = 0.
- istart at edge t -> obusy=1 and state LOOKUP after t.
- oN/oNm1 are valid and state is RUN after t+1.
- The first ival is honoured at edge t+2.
- All outputs are registered. oval/osop/oeop/oaddr appear one cycle after the ival edge that produced them.
- Gapless frame: N beats; odone one cycle after the eop beat; IDLE one cycle later. Total istart-to-IDLE is N+3 cycles.
- A new istart is accepted in the same cycle that IDLE is re-entered.
- ireset_n asserted mid-frame: immediate return to reset values. No odone and no partial eop.
- iclkena=0 during RUN: no beat and no state change, even if ival=1.

## Configuration
- RSC2_FRAME_CTRL_WIMAX_EN defined: WiMAX table compiled in and imode honoured.
- Not defined:
  - imode ignored and DVB table always used.
  - The WiMAX table constant is not referenced, so no storage is inferred.
  - An istart with imode=1 behaves as DVB. oerr is not set for the mode.

## Structure
- Package rsc2_frame_ctrl_pkg holds:
  - DVB and WiMAX length table constants as {N, Nm1} pairs and their size constants.
  - The state enum type.
  - The table-build functions.
- Sub-module rsc2_ntable_rom contains the registered, mode-muxed table read with range check. It outputs N, Nm1 and an out-of-range flag one cycle after its address enable.
- The top level contains the FSM and the counter.

## Test plan
- Reset mid-RUN: DVB entry with N=48, reset after 20 beats -> all outputs 0 at once; no odone; clean restart afterwards.
- Gapless DVB frame, entry with N=48, ival held high:
  - oN=48, oNm1=47.
  - 48 oval beats with oaddr 0..47; osop on 0, oeop on 47.
  - odone one cycle after the eop beat; obusy low after 51 cycles.
- Random ival gaps and iclkena toggling on a 212-duobit entry -> oaddr strictly sequential, exactly 212 beats, no duplicate or missing index.
- iptype=40 (DVB) -> oerr=1, oN=0, no oval and no odone, back to IDLE after 2 cycles. The next valid istart clears oerr.
- istart pulsed during RUN with a different iptype -> ignored; oN unchanged; frame completes at the original length.
- imode=1 with iptype=31: with the macro -> WiMAX entry 31 loaded; without the macro -> DVB entry 31 loaded.
